// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: single-clock FIFO controller in front of a simple dual-port SRAM
// with asynchronous read. Owns the write/read pointers, level tracking and a
// registered output stage so the consumer always sees registered data.
module sram_fifo_ctrl #(
    parameter int unsigned FIFO_WIDTH  = 29,
    parameter int unsigned FIFO_DEPTH  = 128,
    parameter int unsigned ADDR_WIDTH  = 7,
    parameter int unsigned AFULL_LEVEL = 120
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clr,
    // Upstream producer
    input  logic                  i_in_valid,
    input  logic [FIFO_WIDTH-1:0] i_in_data,
    output logic                  o_in_ready,
    // Downstream consumer
    output logic                  o_out_valid,
    output logic [FIFO_WIDTH-1:0] o_out_data,
    input  logic                  i_out_ready,
    // Status
    output logic [ADDR_WIDTH:0]   o_level,
    output logic                  o_almost_full,
    // SRAM write port
    output logic                  o_sram_w_ena,
    output logic [ADDR_WIDTH-1:0] o_sram_w_addr,
    output logic [FIFO_WIDTH-1:0] o_sram_w_data,
    // SRAM read port (combinational read data)
    output logic                  o_sram_r_ena,
    output logic [ADDR_WIDTH-1:0] o_sram_r_addr,
    input  logic [FIFO_WIDTH-1:0] i_sram_r_data
);

    localparam int unsigned PtrW = ADDR_WIDTH + 1;

    logic [PtrW-1:0]       r_wr_ptr;
    logic [PtrW-1:0]       r_rd_ptr;
    logic                  r_out_valid;
    logic [FIFO_WIDTH-1:0] r_out_data;

    logic [PtrW-1:0]       w_mem_cnt;
    logic                  w_mem_empty;
    logic                  w_mem_full;
    logic                  w_push;
    logic                  w_load;
    logic [PtrW-1:0]       w_level;

    // Pointer arithmetic, handshake qualifiers and status, all from registers/inputs.
    always_comb begin
        w_mem_cnt   = r_wr_ptr - r_rd_ptr;
        w_mem_empty = (r_wr_ptr == r_rd_ptr);
        // Count can only range 0..FIFO_DEPTH, so this matches the wrap-bit full test.
        w_mem_full  = (w_mem_cnt == PtrW'(FIFO_DEPTH));
        // Emptiness is judged before this cycle's push, so a word written at an
        // edge is never read through the same address in that cycle.
        w_push      = i_in_valid & ~w_mem_full & ~i_clr;
        w_load      = ~w_mem_empty & (~r_out_valid | i_out_ready) & ~i_clr;
        w_level     = w_mem_cnt + PtrW'(r_out_valid);
    end

    // Drive the SRAM ports and the upstream/downstream interfaces.
    always_comb begin
        o_in_ready    = ~w_mem_full;
        o_sram_w_ena  = w_push;
        o_sram_w_addr = r_wr_ptr[ADDR_WIDTH-1:0];
        o_sram_w_data = i_in_data;
        o_sram_r_ena  = w_load;
        o_sram_r_addr = r_rd_ptr[ADDR_WIDTH-1:0];
        o_out_valid   = r_out_valid;
        o_out_data    = r_out_data;
        o_level       = w_level;
        o_almost_full = (32'(w_level) >= AFULL_LEVEL);
    end

    // Pointer and output-stage state; clr flushes everything but leaves out_data alone.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (i_clr) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_load) begin
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                r_out_data  <= i_sram_r_data;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Scoreboard bench for sram_fifo_ctrl: a driver issues stimulus and keeps a
// word-count model of the FIFO, a negedge monitor pops expected words on every
// downstream handshake and compares the data.
module tb_sram_fifo_ctrl;

    localparam int unsigned W  = 29;
    localparam int unsigned D  = 128;
    localparam int unsigned A  = 7;
    localparam int unsigned AF = 120;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic [A:0]    level;
    logic          almost_full;
    logic          sram_w_ena;
    logic [A-1:0]  sram_w_addr;
    logic [W-1:0]  sram_w_data;
    logic          sram_r_ena;
    logic [A-1:0]  sram_r_addr;
    logic [W-1:0]  sram_r_data;

    logic [W-1:0]  mem [D];

    always #5 clk = ~clk;

    sram_fifo_ctrl #(
        .FIFO_WIDTH (W),
        .FIFO_DEPTH (D),
        .ADDR_WIDTH (A),
        .AFULL_LEVEL(AF)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_clr        (clr),
        .i_in_valid   (in_valid),
        .i_in_data    (in_data),
        .o_in_ready   (in_ready),
        .o_out_valid  (out_valid),
        .o_out_data   (out_data),
        .i_out_ready  (out_ready),
        .o_level      (level),
        .o_almost_full(almost_full),
        .o_sram_w_ena (sram_w_ena),
        .o_sram_w_addr(sram_w_addr),
        .o_sram_w_data(sram_w_data),
        .o_sram_r_ena (sram_r_ena),
        .o_sram_r_addr(sram_r_addr),
        .i_sram_r_data(sram_r_data)
    );

    // SRAM: synchronous write, combinational read.
    always @(posedge clk) begin
        if (sram_w_ena) mem[sram_w_addr] <= sram_w_data;
    end
    assign sram_r_data = mem[sram_r_addr];

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int unsigned n_fail = 0;

    // Reference model: words in SRAM, whether a word sits in the output register,
    // and the expected data stream in order.
    int          m_mem = 0;
    bit          m_ov  = 1'b0;
    logic [W-1:0] exp_q[$];
    int unsigned cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a word is consumed when out_valid & out_ready without a flush.
    always @(negedge clk) begin
        if (rst_n && !clr && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                chk("pop_data", 32'(out_data), 32'(exp_q[0]));
                void'(exp_q.pop_front());
            end
        end
    end

    // Registered-state checks against the model.
    task automatic check_state();
        chk("level", 32'(level), 32'(m_mem + int'(m_ov)));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("in_ready", 32'(in_ready), 32'(m_mem < int'(D)));
        chk("almost_full", 32'(almost_full), 32'((m_mem + int'(m_ov)) >= int'(AF)));
        if (m_ov && exp_q.size() != 0) chk("out_data", 32'(out_data), 32'(exp_q[0]));
    endtask

    // One clock cycle: check, drive, check strobes, advance model, pass the edge.
    task automatic step(input bit iv, input logic [W-1:0] d, input bit ord, input bit fl);
        bit acc;
        bit ld;
        check_state();
        in_valid  = iv;
        in_data   = d;
        out_ready = ord;
        clr       = fl;
        acc = iv && (m_mem < int'(D)) && !fl;
        ld  = (m_mem > 0) && (!m_ov || ord) && !fl;
        #1;
        chk("sram_w_ena", 32'(sram_w_ena), 32'(acc));
        chk("sram_r_ena", 32'(sram_r_ena), 32'(ld));
        if (acc) chk("sram_w_addr_data", 32'(sram_w_data), 32'(d));
        if (fl) begin
            m_mem = 0;
            m_ov  = 1'b0;
            exp_q.delete();
        end else begin
            if (ld) begin
                m_mem--;
                m_ov = 1'b1;
            end else if (m_ov && ord) begin
                m_ov = 1'b0;
            end
            if (acc) begin
                m_mem++;
                exp_q.push_back(d);
            end
        end
        if (acc) cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit ord);
        for (int i = 0; i < n; i++) step(1'b0, '0, ord, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #7;
        chk("rst_level", 32'(level), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Hold 50 words, then assert reset mid-stream.
        cnt = 0;
        for (int i = 0; i < 50; i++) step(1'b1, W'(cnt + 32'h100), 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_level", 32'(level), 0);
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_in_ready", 32'(in_ready), 1);
        m_mem = 0; m_ov = 1'b0; exp_q.delete();
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b1;
        step(1'b1, W'(32'h1ABCDEF0), 1'b1, 1'b0);
        chk("lat_after_1_edge", 32'(out_valid), 0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("lat_valid_2_edges", 32'(out_valid), 1);
        chk("lat_data_2_edges", 32'(out_data), 32'h1ABCDEF0);
        idle(3, 1'b1);

        // Fill to capacity with out_ready low: 129 words expected.
        cnt = 0;
        for (int i = 0; i < 135; i++) step(1'b1, W'(cnt), 1'b0, 1'b0);
        chk("fill_accepts", cnt, D + 1);
        chk("fill_level", 32'(level), D + 1);
        chk("fill_in_ready", 32'(in_ready), 0);
        chk("fill_out_data", 32'(out_data), 0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("pop_out_data", 32'(out_data), 1);
        chk("pop_in_ready", 32'(in_ready), 1);
        idle(140, 1'b1);

        // Flush with 40 words held and a concurrent push.
        for (int i = 0; i < 40; i++) step(1'b1, W'(i + 500), 1'b0, 1'b0);
        step(1'b1, W'(32'h777), 1'b1, 1'b1);
        chk("flush_level", 32'(level), 0);
        chk("flush_out_valid", 32'(out_valid), 0);
        clr = 1'b0;
        step(1'b1, W'(5), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("flush_next_data", 32'(out_data), 5);
        idle(3, 1'b1);

        // Streaming: 300 words through with both sides always ready.
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            step(1'b1, W'(cnt), 1'b1, 1'b0);
            if (i >= 2) chk("stream_level", 32'(level), 2);
        end
        idle(5, 1'b1);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), W'($urandom), ($urandom_range(0, 3) != 0) ^ (i[11]),
                 ($urandom_range(0, 399) == 0));
        end
        clr = 1'b0;
        idle(140, 1'b1);
        chk("drained", exp_q.size(), 0);
        check_state();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sram_fifo_ctrl.md
# sram_fifo_ctrl

Single-clock FIFO controller that drives a simple dual-port SRAM with asynchronous read (synchronous write, combinational `r_data = MEM[r_addr]`). It sits between an upstream valid/ready producer and a downstream valid/ready consumer. It owns the write/read pointers, full/empty/level tracking and a registered output stage, so the consumer sees registered data. Both SRAM clock inputs are tied to `clk` at the instantiating level.

## Interface

**Parameters**
- `FIFO_WIDTH`, 29, data word width; must match the SRAM.
- `FIFO_DEPTH`, 128, SRAM entries; must equal 2^`ADDR_WIDTH`.
- `ADDR_WIDTH`, 7, SRAM address width.
- `AFULL_LEVEL`, 120, `almost_full` threshold on `level`.

**Ports**
- `clk` in 1: single clock for all logic and both SRAM ports.
- `rst_n` in 1: asynchronous, active-low reset.
- `clr` in 1: synchronous flush.
- `in_valid` in 1: upstream word present.
- `in_data` in `FIFO_WIDTH`: upstream word.
- `in_ready` out 1: controller accepts the word this cycle.
- `out_valid` out 1: `out_data` holds a valid word.
- `out_data` out `FIFO_WIDTH`: registered output word.
- `out_ready` in 1: downstream takes the word this cycle.
- `level` out `ADDR_WIDTH+1`: words held (SRAM plus output register), range 0..`FIFO_DEPTH+1`.
- `almost_full` out 1: `level >= AFULL_LEVEL`.
- `sram_w_ena` out 1: SRAM write enable.
- `sram_w_addr` out `ADDR_WIDTH`: SRAM write address.
- `sram_w_data` out `FIFO_WIDTH`: SRAM write data.
- `sram_r_ena` out 1: SRAM read strobe (informational; the SRAM read is combinational).
- `sram_r_addr` out `ADDR_WIDTH`: SRAM read address.
- `sram_r_data` in `FIFO_WIDTH`: SRAM read data, combinational from `sram_r_addr`.

## Operation

**Pointers**
- `wr_ptr` and `rd_ptr` are `ADDR_WIDTH+1` bits. The low bits address the SRAM; the MSB is the wrap bit.
- Pointers wrap modulo 2^(`ADDR_WIDTH+1`).
- `mem_cnt` = `wr_ptr - rd_ptr`, computed modulo 2^(`ADDR_WIDTH+1`).
- `mem_empty` = pointers equal.
- `mem_full` = low bits equal and MSBs differ.

**Write side**
- `in_ready = !mem_full`. It is combinational and independent of `out_ready` (no full-FIFO bypass).
- `push = in_valid & in_ready & !clr`.
- `sram_w_ena = push`, `sram_w_addr = wr_ptr[ADDR_WIDTH-1:0]`, `sram_w_data = in_data`.
- `wr_ptr` increments on `push`.

**Output stage**
- `sram_r_addr = rd_ptr[ADDR_WIDTH-1:0]` at all times.
- `load = !mem_empty & (!out_valid | out_ready) & !clr`.
- `sram_r_ena = load`.
- On `load`: `out_data <= sram_r_data`, `out_valid <= 1`, `rd_ptr` increments.
- If `out_valid & out_ready & !load`: `out_valid <= 0`. `out_data` holds its value.
- `mem_empty` is evaluated before this cycle's `push`. A word written at edge N is loadable no earlier than edge N+1, so the read and write addresses never collide in the same cycle.

**Level**
- `level = mem_cnt + out_valid`, combinational from registers.
- `almost_full` is combinational from `level`.

**Flush (`clr`)**
- On the next edge: both pointers reset to 0 and `out_valid <= 0`.
- `clr` overrides `push` and `load` that cycle.
- `in_ready` still follows `mem_full` during `clr`, but the word is dropped.

**Reset (`rst_n` low, asynchronous)**
- Pointers = 0, `out_valid` = 0, `out_data` = 0.
- Therefore `level` = 0, `in_ready` = 1, `almost_full` = 0.
- SRAM contents are not cleared.
- Reset asserted mid-transfer discards all held words. The first accept after release behaves as from empty.

## Timing

- Accept-to-visible latency, empty FIFO, `out_ready` = 1: word accepted at edge N; `out_valid` high after edge N+1 with that word. Latency is 2 edges.
- Steady-state throughput: 1 word per cycle in and out, simultaneously.
- Capacity: `FIFO_DEPTH+1` words (128 in SRAM plus 1 in the output register). `in_ready` deasserts only when the SRAM holds `FIFO_DEPTH`.
- At `mem_full` with a pop: `in_ready` rises the cycle after `rd_ptr` increments.
- `out_data` changes only on `load` and never glitches. While `out_valid & !out_ready`, `out_data` is stable.
- Ordering is strict FIFO across any number of pointer wraps.

## Test plan

- **Reset:** assert `rst_n`=0 mid-stream with 50 words held -> `level`=0, `out_valid`=0, `in_ready`=1 immediately. After release, push 0x1ABCDEF0 -> `out_data`=0x1ABCDEF0, `out_valid`=1 two edges after accept.
- **Fill:** `out_ready`=0, push 0..128 -> 129 accepts. `in_ready`=0 after the 129th, `level`=129, `almost_full`=1 from `level`=120, `out_data`=0. One pop -> `out_data`=1, and `in_ready`=1 one cycle later.
- **Streaming:** `in_valid`=`out_ready`=1 continuously for 300 words (counter data) -> output sequence 0..299 in order, no gaps after the initial 2-cycle fill, `level` constant at 2. This covers pointer wrap twice.
- **Random backpressure:** random `in_valid`/`out_ready` for 10k cycles with a scoreboard -> no loss, duplication or reorder. `level` always equals scoreboard depth. `sram_w_ena` never asserts while `mem_full`.
- **Flush:** with 40 words held, pulse `clr` one cycle together with `in_valid`=1 and `out_ready`=1 -> next cycle `level`=0, `out_valid`=0, and the concurrent push is discarded. A following push 0x5 -> `out_data`=0x5.
- **Empty boundary:** push one word, hold `out_ready`=1 -> exactly one `out_valid` cycle. `sram_r_ena` is never high while `mem_empty`.
